// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline: branch resolution, loads/stores over a req/ack
// data-memory port, and the registered MEM/WB outputs.
module mem_access_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   input  logic        Branch_in,
   input  logic        Zero_in,
   input  logic        is_greater_in,
   input  logic        MemWrite_in,
   input  logic        MemRead_in,
   input  logic [63:0] immvalue_added_pc_in,
   input  logic [63:0] ALU_result_in,
   input  logic [63:0] WriteData_in,
   input  logic [3:0]  ALU_OP_in,
   input  logic [4:0]  dest_reg_in,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_be,
   output logic [63:0] mem_wdata,
   output logic        pc_src,
   output logic [63:0] branch_target,
   output logic        flush_out,
   output logic        stall_out,
   output logic        misalign_err,
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic        valid_out,
   output logic [63:0] read_data_out,
   output logic [63:0] ALU_result_out,
   output logic [4:0]  dest_reg_out
);

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_next;

   logic        mem_op, misaligned, accept, ack_seen, taken;
   logic [1:0]  size;
   logic [7:0]  size_mask;
   logic [63:0] load_shifted, load_ext;
   logic        lat_regwrite, lat_memtoreg, lat_store, lat_unsigned;
   logic [1:0]  lat_size;
   logic [2:0]  lat_lane;
   logic [63:0] lat_alu;
   logic [4:0]  lat_dest;
   logic        unused_op_bit;

   assign unused_op_bit = ALU_OP_in[3];
   assign size          = ALU_OP_in[1:0];
   assign mem_op        = MemRead_in | MemWrite_in;

   // Loads and stores share the size encoding in the low two bits (111 folds onto LD).
   always_comb begin
      size_mask  = 8'h01;
      misaligned = 1'b0;
      case (size)
         2'd0: begin size_mask = 8'h01; misaligned = 1'b0; end
         2'd1: begin size_mask = 8'h03; misaligned = ALU_result_in[0]; end
         2'd2: begin size_mask = 8'h0F; misaligned = |ALU_result_in[1:0]; end
         default: begin size_mask = 8'hFF; misaligned = |ALU_result_in[2:0]; end
      endcase
   end

   assign accept    = (state == IDLE) && mem_op && !misaligned;
   assign ack_seen  = (state == BUSY) && mem_req && mem_ack;
   assign stall_out = accept || ((state == BUSY) && !ack_seen);

   always_comb begin
      taken = 1'b0;
      case (ALU_OP_in[2:0])
         3'b000:  taken = Zero_in;
         3'b001:  taken = !Zero_in;
         3'b100:  taken = !is_greater_in && !Zero_in;
         3'b101:  taken = is_greater_in || Zero_in;
         default: taken = 1'b0;
      endcase
   end

   assign pc_src        = (state == IDLE) && Branch_in && taken;
   assign flush_out     = pc_src;
   assign branch_target = immvalue_added_pc_in;

   assign load_shifted = mem_rdata >> {lat_lane, 3'b000};

   always_comb begin
      load_ext = load_shifted;
      case (lat_size)
         2'd0: load_ext = lat_unsigned ? {56'd0, load_shifted[7:0]}
                                       : {{56{load_shifted[7]}}, load_shifted[7:0]};
         2'd1: load_ext = lat_unsigned ? {48'd0, load_shifted[15:0]}
                                       : {{48{load_shifted[15]}}, load_shifted[15:0]};
         2'd2: load_ext = lat_unsigned ? {32'd0, load_shifted[31:0]}
                                       : {{32{load_shifted[31]}}, load_shifted[31:0]};
         default: load_ext = load_shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)   state_next = BUSY;
         BUSY:    if (ack_seen) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // While BUSY the MEM/WB register keeps the bubble written at accept time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= 64'd0;
         mem_be         <= 8'd0;
         mem_wdata      <= 64'd0;
         misalign_err   <= 1'b0;
         valid_out      <= 1'b0;
         RegWrite_out   <= 1'b0;
         MemtoReg_out   <= 1'b0;
         read_data_out  <= 64'd0;
         ALU_result_out <= 64'd0;
         dest_reg_out   <= 5'd0;
         lat_regwrite   <= 1'b0;
         lat_memtoreg   <= 1'b0;
         lat_store      <= 1'b0;
         lat_unsigned   <= 1'b0;
         lat_size       <= 2'd0;
         lat_lane       <= 3'd0;
         lat_alu        <= 64'd0;
         lat_dest       <= 5'd0;
      end else begin
         misalign_err <= 1'b0;
         if (state == IDLE) begin
            if (!mem_op) begin
               valid_out      <= 1'b1;
               RegWrite_out   <= RegWrite_in;
               MemtoReg_out   <= MemtoReg_in;
               read_data_out  <= 64'd0;
               ALU_result_out <= ALU_result_in;
               dest_reg_out   <= dest_reg_in;
            end else begin
               valid_out      <= 1'b0;
               RegWrite_out   <= 1'b0;
               MemtoReg_out   <= 1'b0;
               read_data_out  <= 64'd0;
               ALU_result_out <= 64'd0;
               dest_reg_out   <= 5'd0;
               if (misaligned) begin
                  misalign_err <= 1'b1;
               end else begin
                  mem_req      <= 1'b1;
                  mem_we       <= MemWrite_in;
                  mem_addr     <= {ALU_result_in[63:3], 3'b000};
                  mem_be       <= MemWrite_in ? (size_mask << ALU_result_in[2:0]) : 8'h00;
                  mem_wdata    <= MemWrite_in ? (WriteData_in << {ALU_result_in[2:0], 3'b000}) : 64'd0;
                  lat_regwrite <= RegWrite_in;
                  lat_memtoreg <= MemtoReg_in;
                  lat_store    <= MemWrite_in;
                  lat_unsigned <= ALU_OP_in[2];
                  lat_size     <= size;
                  lat_lane     <= ALU_result_in[2:0];
                  lat_alu      <= ALU_result_in;
                  lat_dest     <= dest_reg_in;
               end
            end
         end else if (ack_seen) begin
            mem_req        <= 1'b0;
            valid_out      <= 1'b1;
            RegWrite_out   <= lat_regwrite;
            MemtoReg_out   <= lat_memtoreg;
            read_data_out  <= lat_store ? 64'd0 : load_ext;
            ALU_result_out <= lat_alu;
            dest_reg_out   <= lat_dest;
         end
      end
   end

endmodule
